// File: rtl/pulsegen_pkg.sv
// Shared types for the pulse generator: FSM state encoding and default widths.
package pulsegen_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAct   = 2'd1,
        StInact = 2'd2
    } state_e;

    localparam int unsigned DefBw  = 8;
    localparam int unsigned DefRcw = 8;

endpackage

// File: rtl/pulsegen_cnt.sv
// Phase tick counter: counts refclk ticks, flags the tick that completes a phase of length term.
module pulsegen_cnt #(
    parameter int unsigned BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [BW-1:0] term,
    output logic [BW-1:0] cnt,
    output logic          hit
);

    logic [BW-1:0] cnt_q, cnt_d;

    // term is never zero here, so term-1 cannot underflow.
    assign hit = en && (cnt_q == (term - BW'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pulsegen.sv
// GPIO pulse generator: N pulses or a continuous train with programmable active/inactive widths
// counted in refclk ticks, polarity-selectable pad output.
module pulsegen
    import pulsegen_pkg::*;
#(
    parameter int unsigned BW  = DefBw,
    parameter int unsigned RCW = DefRcw
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           refclk,
    input  logic           pol,
    input  logic           start,
    input  logic           stop,
    input  logic [BW-1:0]  act_st,
    input  logic [BW-1:0]  inact_st,
    input  logic [RCW-1:0] rep_st,
    output logic           data_out,
    output logic           act_edge,
    output logic           inact_edge,
    output logic           busy,
    output logic           done
);

    state_e         state_q, state_d;
    logic           act_q, act_d;
    logic           act_edge_q, act_edge_d;
    logic           inact_edge_q, inact_edge_d;
    logic           done_q, done_d;
    logic [RCW-1:0] pcnt_q, pcnt_d;
    logic [BW-1:0]  act_lat_q, act_lat_d;
    logic [BW-1:0]  inact_lat_q, inact_lat_d;
    logic [RCW-1:0] rep_lat_q, rep_lat_d;

    logic          launch;
    logic          last;
    logic          cnt_clr;
    logic          cnt_en;
    logic          hit;
    logic [BW-1:0] term;
    logic [BW-1:0] cnt;

    assign launch  = (state_q == StIdle) && start && !stop;
    assign last    = (rep_lat_q != '0) && (pcnt_q == rep_lat_q);
    assign term    = (state_q == StInact) ? inact_lat_q : act_lat_q;
    assign cnt_en  = refclk && (state_q != StIdle);
    assign cnt_clr = (state_q == StIdle) || stop || hit;

    pulsegen_cnt #(
        .BW (BW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (term),
        .cnt   (cnt),
        .hit   (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            act_q        <= 1'b0;
            act_edge_q   <= 1'b0;
            inact_edge_q <= 1'b0;
            done_q       <= 1'b0;
            pcnt_q       <= '0;
            act_lat_q    <= '0;
            inact_lat_q  <= '0;
            rep_lat_q    <= '0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            act_edge_q   <= act_edge_d;
            inact_edge_q <= inact_edge_d;
            done_q       <= done_d;
            pcnt_q       <= pcnt_d;
            act_lat_q    <= act_lat_d;
            inact_lat_q  <= inact_lat_d;
            rep_lat_q    <= rep_lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StAct;
                StAct:   if (hit) state_d = last ? StIdle : StInact;
                StInact: if (hit) state_d = StAct;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        act_d        = (state_d == StAct);
        act_edge_d   = act_d && !act_q;
        inact_edge_d = !act_d && act_q;
        done_d       = !stop && (state_q == StAct) && hit && last;

        act_lat_d   = act_lat_q;
        inact_lat_d = inact_lat_q;
        rep_lat_d   = rep_lat_q;
        pcnt_d      = pcnt_q;
        if (launch) begin
            act_lat_d   = (act_st == '0) ? BW'(1) : act_st;
            inact_lat_d = (inact_st == '0) ? BW'(1) : inact_st;
            rep_lat_d   = rep_st;
            pcnt_d      = RCW'(1);
        end else if (!stop && (state_q == StInact) && hit && (pcnt_q != '1)) begin
            // Only continuous mode can reach the ceiling; there it just sticks.
            pcnt_d = pcnt_q + RCW'(1);
        end
    end

    assign data_out   = pol ? act_q : ~act_q;
    assign act_edge   = act_edge_q;
    assign inact_edge = inact_edge_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;

endmodule

// File: tb/tb_pulsegen.sv
// Self-checking bench for pulsegen: directed scenarios plus random traffic against a
// phase-countdown reference model.
module tb_pulsegen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       refclk = 1'b1;
    logic       pol = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] act_st = '0;
    logic [7:0] inact_st = '0;
    logic [7:0] rep_st = '0;
    logic       data_out, act_edge, inact_edge, busy, done;

    int checks = 0;
    int failures = 0;

    // Reference model: current level, ticks left in the phase, pulses emitted.
    bit m_busy, m_act, m_ae, m_ie, m_done;
    int m_rem, m_pulses, m_a, m_i, m_r;

    pulsegen #(
        .BW  (8),
        .RCW (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .refclk     (refclk),
        .pol        (pol),
        .start      (start),
        .stop       (stop),
        .act_st     (act_st),
        .inact_st   (inact_st),
        .rep_st     (rep_st),
        .data_out   (data_out),
        .act_edge   (act_edge),
        .inact_edge (inact_edge),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_act = 0; m_ae = 0; m_ie = 0; m_done = 0;
        m_rem = 0; m_pulses = 0; m_a = 0; m_i = 0; m_r = 0;
    endtask

    task automatic model_step();
        m_ae = 0; m_ie = 0; m_done = 0;
        if (stop) begin
            m_ie = m_act;
            m_busy = 0;
            m_act = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_a = (act_st == 0) ? 1 : int'(act_st);
                m_i = (inact_st == 0) ? 1 : int'(inact_st);
                m_r = int'(rep_st);
                m_busy = 1; m_act = 1; m_ae = 1;
                m_rem = m_a;
                m_pulses = 1;
            end
        end else if (refclk) begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_act) begin
                    m_act = 0; m_ie = 1;
                    if (m_r != 0 && m_pulses == m_r) begin
                        m_busy = 0; m_done = 1;
                    end else begin
                        m_rem = m_i;
                    end
                end else begin
                    m_act = 1; m_ae = 1;
                    m_rem = m_a;
                    m_pulses++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("data_out", data_out, pol ? m_act : !m_act);
        check("act_edge", act_edge, m_ae);
        check("inact_edge", inact_edge, m_ie);
        check("busy", busy, m_busy);
        check("done", done, m_done);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int hi;
        int dn;
        model_reset();
        #12;
        check_outputs();
        check("rst_data_out", data_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Polarity flip is immediate and edge-free.
        pol = 1'b0;
        #1;
        check_outputs();
        check("pol_flip", data_out, 1'b1);
        repeat (2) cycle();

        // 3 high, 2 low, 3 high, done once.
        pol = 1'b1; refclk = 1'b1;
        act_st = 8'd3; inact_st = 8'd2; rep_st = 8'd2;
        hi = 0; dn = 0;
        pulse_start();
        hi += int'(data_out); dn += int'(done);
        for (int k = 0; k < 12; k++) begin
            cycle();
            hi += int'(data_out); dn += int'(done);
        end
        check("t2_high_clks", hi, 6);
        check("t2_done_count", dn, 1);

        // refclk period 3, act 8 ticks: width within [22,24] clk.
        act_st = 8'd8; rep_st = 8'd1; hi = 0;
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            refclk = (k % 3 == 0);
            hi += int'(data_out);
            cycle();
        end
        check("t3_width_in_range", (hi >= 22 && hi <= 24), 1);
        refclk = 1'b1;

        // Continuous square wave, then stop.
        act_st = 8'd1; inact_st = 8'd1; rep_st = 8'd0;
        pulse_start();
        for (int k = 0; k < 50; k++) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("t4_stopped", data_out, 1'b0);
        repeat (2) cycle();

        // start and stop together: stop wins.
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        check("t5_no_busy", busy, 1'b0);
        // Restart while busy with different settings is ignored.
        act_st = 8'd4; rep_st = 8'd1;
        pulse_start();
        act_st = 8'd9;
        pulse_start();
        for (int k = 0; k < 8; k++) cycle();

        // Zero widths act as 1; reset mid-pulse returns to reset values at once.
        act_st = 8'd0; inact_st = 8'd0; rep_st = 8'd3;
        pulse_start();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("t6_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            refclk   = ($urandom_range(0, 2) != 0);
            start    = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 150) == 0);
            act_st   = 8'($urandom_range(0, 5));
            inact_st = 8'($urandom_range(0, 5));
            rep_st   = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 200) == 0) pol = ~pol;
            cycle();
        end
        start = 1'b0; stop = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
